// File: rtl/psdsquare_pkg.sv
// Shared definitions for the squarer and its square-root companion.
package psdsquare_pkg;

   localparam int unsigned PSD_NBITS = 16;

   typedef enum logic [1:0] {
      PSD_IDLE = 2'd0,
      PSD_RUN  = 2'd1,
      PSD_DONE = 2'd2
   } psd_state_e;

endpackage

// File: rtl/psdsquare_if.sv
// Control/data bundle for the squarer: start/stop pulses, operand in,
// result and status out.
interface psdsquare_if
   import psdsquare_pkg::*;
#(
   parameter int unsigned NBITS = PSD_NBITS
);

   logic               start;
   logic               stop;
   logic [NBITS-1:0]   xin;
   logic [2*NBITS-1:0] sq;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, xin,
      input  sq, busy, done
   );

   modport slave (
      input  start, stop, xin,
      output sq, busy, done
   );

endinterface

// File: rtl/psdsquare.sv
// Iterative unsigned squarer: one shift-and-add step per clock, NBITS steps
// per square. The output register is loaded from the accumulator on stop.
module psdsquare
   import psdsquare_pkg::*;
#(
   parameter int unsigned NBITS = PSD_NBITS
) (
   input  logic         clock,
   input  logic         reset,
   psdsquare_if.slave   bus
);

   localparam int unsigned CNTW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBITS - 1);

   psd_state_e         state_q;
   logic [2*NBITS-1:0] acc_q;
   logic [2*NBITS-1:0] acc_d;
   logic [2*NBITS-1:0] mcand_q;
   logic [NBITS-1:0]   mul_q;
   logic [CNTW-1:0]    cnt_q;
   logic [2*NBITS-1:0] sq_q;
   logic               busy_q;
   logic               done_q;

   // Next accumulator value for one shift-and-add step.
   always_comb begin
      acc_d = acc_q;
      if (mul_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   // Control FSM, datapath and output register. Stop captures the
   // pre-edge accumulator, so a simultaneous start/stop sees the old sum.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= PSD_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mul_q   <= '0;
         cnt_q   <= '0;
         sq_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (bus.stop) begin
            sq_q <= acc_q;
         end
         if (bus.start) begin
            acc_q   <= '0;
            mcand_q <= {{NBITS{1'b0}}, bus.xin};
            mul_q   <= bus.xin;
            cnt_q   <= '0;
            state_q <= PSD_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
         end else if (state_q == PSD_RUN) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 1;
            mul_q   <= mul_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_q <= PSD_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.sq   = sq_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_psdsquare.sv
// Scoreboard bench for psdsquare: stimulus pushes the expected sq/busy/done
// whenever it issues stop; a monitor pops and compares after each stop edge.
module tb_psdsquare;

   logic clock = 1'b0;
   logic reset = 1'b0;

   psdsquare_if #(.NBITS(16)) bus ();

   psdsquare #(.NBITS(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       tag;
      logic [31:0] sq;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input string field,
                        input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s: got 0x%08h want 0x%08h", tag, field, act, req);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_stop(input string tag, input logic [31:0] sq,
                              input logic busy, input logic done);
      exp_t e;
      e.tag  = tag;
      e.sq   = sq;
      e.busy = busy;
      e.done = done;
      exp_q.push_back(e);
   endtask

   // Issue stop on the next edge with the given expectation.
   task automatic do_stop(input string tag, input logic [31:0] sq,
                          input logic busy, input logic done);
      expect_stop(tag, sq, busy, done);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
   endtask

   // Start pulse sampled at E0; xin scrambled afterwards.
   task automatic pulse_start(input logic [15:0] x);
      bus.start = 1'b1;
      bus.xin   = x;
      step();
      bus.start = 1'b0;
      bus.xin   = 16'($urandom);
   endtask

   // Full square with stop at E17, the first edge giving the final result.
   task automatic run_full(input string tag, input logic [15:0] x);
      pulse_start(x);
      repeat (16) step();
      do_stop(tag, 32'(x) * 32'(x), 1'b0, 1'b1);
   endtask

   // Monitor: each edge that samples stop produces one observable result.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         if (bus.stop) begin
            #2;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_stop: got sq=0x%08h want no output", bus.sq);
            end else begin
               e = exp_q.pop_front();
               check(e.tag, "sq",   bus.sq,          e.sq);
               check(e.tag, "busy", 32'(bus.busy),   32'(e.busy));
               check(e.tag, "done", 32'(bus.done),   32'(e.done));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] rv;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.xin   = '0;

      // Reset wins over a simultaneous stop.
      reset = 1'b1;
      step();
      do_stop("reset", 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
      step();

      run_full("x0",    16'h0000);
      run_full("x3",    16'h0003);
      run_full("xffff", 16'hFFFF);
      run_full("x8000", 16'h8000);

      // Restart at E5 with stop in the same cycle: sq takes 0x1234 after
      // four steps (bit 2 only -> 0x1234<<2), busy stays high.
      pulse_start(16'h1234);
      repeat (4) step();
      expect_stop("restart_old", 32'h0000_48D0, 1'b1, 1'b0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      bus.xin   = 16'h0010;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.xin   = 16'hABCD;
      repeat (16) step();
      do_stop("restart_new", 32'h0000_0100, 1'b0, 1'b1);

      // Reset at E8 mid-run (with stop) clears everything; done stays low.
      pulse_start(16'hFFFF);
      repeat (7) step();
      reset = 1'b1;
      do_stop("reset_mid", 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (20) step();
      do_stop("after_reset", 32'h0, 1'b0, 1'b0);

      // Partial sum: stop sampled at E5 sees four steps, 0xFF*0xF.
      pulse_start(16'h00FF);
      repeat (4) step();
      do_stop("partial", 32'h0000_0EF1, 1'b1, 1'b0);
      repeat (11) step();
      do_stop("partial_final", 32'h0000_FE01, 1'b0, 1'b1);
      repeat (5) step();
      do_stop("done_hold", 32'h0000_FE01, 1'b0, 1'b1);

      // A few random operands against the arithmetic square.
      for (int i = 0; i < 8; i++) begin
         rv = 16'($urandom);
         run_full("rand", rv);
      end

      repeat (3) step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
